// File: rtl/arb_pkg.sv
// Shared definitions for the datapath arbiter: state encoding and default sizing.
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    GRANT   = 3'b001,
    RUN     = 3'b010,
    RELEASE = 3'b011,
    ABORT   = 3'b100
  } state_t;

  localparam int unsigned DEF_N       = 4;
  localparam int unsigned DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward, cyclically,
// from (last+1) mod N. Reusable by any shared-resource arbiter.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  int unsigned     c;
  logic [IDXW-1:0] ci;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    c      = 0;
    ci     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      c  = (32'(last) + k) % N;
      ci = c[IDXW-1:0];
      if (!any && req[ci]) begin
        any        = 1'b1;
        idx        = ci;
        onehot[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/datapath_arbiter.sv
// Round-robin scheduler sharing one iterative multiply/add datapath among N units.
// Optional run-time abort is enabled by defining ARB_TIMEOUT_EN.
module datapath_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned IDXW    = $clog2(N),
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    ack,
  output logic [IDXW-1:0] sel_src,
  output logic            dp_start,
  input  logic            dp_done,
  output logic            busy,
  output logic            err
);

  state_t          state, next;
  logic [IDXW-1:0] last, last_d;
  logic [N-1:0]    win_onehot;
  logic [IDXW-1:0] win_idx;
  logic            win_any;
  logic [N-1:0]    gnt_d, ack_d;
  logic [IDXW-1:0] sel_d;
  logic            start_d, busy_d, err_d;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req    (req),
    .last   (last),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  // Cleared while in GRANT so it reads zero on the first RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (state == GRANT) cnt <= '0;
    else if (state == RUN)   cnt <= cnt + 1'b1;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (win_any) next = GRANT;
      GRANT:   next = RUN;
      RUN:     if (dp_done) next = RELEASE;
`ifdef ARB_TIMEOUT_EN
               else if (cnt == CW'(TIMEOUT)) next = ABORT;
`endif
      RELEASE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Outputs are computed from the transition so they can be registered with the state.
  always_comb begin
    gnt_d   = gnt;
    sel_d   = sel_src;
    last_d  = last;
    ack_d   = '0;
    err_d   = 1'b0;
    start_d = (next == GRANT);
    busy_d  = (next != IDLE);
    unique case (state)
      IDLE: if (win_any) begin
        gnt_d  = win_onehot;
        sel_d  = win_idx;
        last_d = win_idx;
      end
      RUN: begin
        if (next == RELEASE) begin
          ack_d = gnt;
          gnt_d = '0;
        end else if (next == ABORT) begin
          err_d = 1'b1;
          gnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      ack      <= '0;
      sel_src  <= '0;
      dp_start <= 1'b0;
      busy     <= 1'b0;
      last     <= IDXW'(N - 1);
    end else begin
      gnt      <= gnt_d;
      ack      <= ack_d;
      sel_src  <= sel_d;
      dp_start <= start_d;
      busy     <= busy_d;
      last     <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= err_d;
  end
`else
  logic unused_err_d;
  assign unused_err_d = err_d;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed self-checking bench for datapath_arbiter (N=4, TIMEOUT=8).
module tb_datapath_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] ack;
  logic [1:0] sel_src;
  logic       dp_start;
  logic       dp_done;
  logic       busy;
  logic       err;

  int n_cmp = 0;
  int n_err = 0;

  datapath_arbiter #(.N(4), .IDXW(2), .TIMEOUT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .ack      (ack),
    .sel_src  (sel_src),
    .dp_start (dp_start),
    .dp_done  (dp_done),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] order [5];

  initial begin
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1; req = '0; dp_done = 1'b0;
    tick(); tick();
    chk("rst_gnt", 8'(gnt), 8'h0);
    chk("rst_ack", 8'(ack), 8'h0);
    chk("rst_sel", 8'(sel_src), 8'h0);
    chk("rst_start", 8'(dp_start), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_err", 8'(err), 8'h0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 8'(busy), 8'h0);

    // Single request, done 5 cycles after start
    req = 4'b0100;
    tick();
    chk("single_gnt", 8'(gnt), 8'h4);
    chk("single_sel", 8'(sel_src), 8'h2);
    chk("single_busy", 8'(busy), 8'h1);
    chk("single_start", 8'(dp_start), 8'h1);
    req = '0;
    tick();
    chk("single_start_low", 8'(dp_start), 8'h0);
    chk("single_run_gnt", 8'(gnt), 8'h4);
    repeat (4) tick();
    chk("single_no_early_ack", 8'(ack), 8'h0);
    dp_done = 1'b1;
    tick();
    chk("single_ack", 8'(ack), 8'h4);
    chk("single_rel_gnt", 8'(gnt), 8'h0);
    dp_done = 1'b0;
    tick();
    chk("single_ack_pulse", 8'(ack), 8'h0);
    chk("single_idle_busy", 8'(busy), 8'h0);
    chk("single_sel_hold", 8'(sel_src), 8'h2);

    // Fairness with all requests held and done always high
    rst = 1'b1; #1; rst = 1'b0;
    req = 4'b1111; dp_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (i == 0 ? 1 : 4) tick();
      chk($sformatf("fair_gnt%0d", i), 8'(gnt), 8'(order[i]));
    end
    req = '0;
    tick(); tick();
    chk("fair_last_ack", 8'(ack), 8'h1);
    tick();
    chk("fair_idle", 8'(busy), 8'h0);
    dp_done = 1'b0;

    // Late arrival of req[3] during requester 1's RUN
    req = 4'b0010;
    tick();
    chk("late_gnt1", 8'(gnt), 8'h2);
    tick();
    req = 4'b1000;
    tick();
    chk("late_no_preempt", 8'(gnt), 8'h2);
    dp_done = 1'b1;
    tick();
    chk("late_ack1", 8'(ack), 8'h2);
    dp_done = 1'b0;
    tick();
    chk("late_idle_gnt", 8'(gnt), 8'h0);
    tick();
    chk("late_gnt3", 8'(gnt), 8'h8);
    chk("late_sel3", 8'(sel_src), 8'h3);
    req = '0;
    tick();
    dp_done = 1'b1;
    tick();
    chk("late_ack3", 8'(ack), 8'h8);
    dp_done = 1'b0;
    tick();

    // Request dropped mid-service still gets ack
    req = 4'b0100;
    tick();
    chk("drop_gnt", 8'(gnt), 8'h4);
    tick();
    req = '0;
    tick();
    chk("drop_hold_gnt", 8'(gnt), 8'h4);
    dp_done = 1'b1;
    tick();
    chk("drop_ack", 8'(ack), 8'h4);
    dp_done = 1'b0;
    tick();
    chk("drop_idle", 8'(busy), 8'h0);

    // Asynchronous reset mid-RUN
    req = 4'b0010;
    tick(); tick();
    chk("rstrun_busy", 8'(busy), 8'h1);
    rst = 1'b1;
    #1;
    chk("rstrun_gnt", 8'(gnt), 8'h0);
    chk("rstrun_busy0", 8'(busy), 8'h0);
    chk("rstrun_sel", 8'(sel_src), 8'h0);
    req = 4'b1001;
    tick();
    chk("rstrun_no_ack", 8'(ack), 8'h0);
    rst = 1'b0;
    tick();
    chk("rstrun_next_gnt", 8'(gnt), 8'h1);
    chk("rstrun_next_sel", 8'(sel_src), 8'h0);
    req = '0;
    tick();
    dp_done = 1'b1;
    tick();
    chk("rstrun_ack", 8'(ack), 8'h1);
    dp_done = 1'b0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // Timeout abort with dp_done held low
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    repeat (8) tick();
    chk("to_not_yet", 8'(err), 8'h0);
    chk("to_gnt_held", 8'(gnt), 8'h2);
    tick();
    chk("to_err", 8'(err), 8'h1);
    chk("to_gnt_clr", 8'(gnt), 8'h0);
    chk("to_no_ack", 8'(ack), 8'h0);
    tick();
    chk("to_err_pulse", 8'(err), 8'h0);
    chk("to_idle", 8'(busy), 8'h0);
    req = 4'b0011;
    tick();
    chk("to_next_gnt", 8'(gnt), 8'h1);
    req = '0;
    tick();
    dp_done = 1'b1;
    tick();
    chk("to_next_ack", 8'(ack), 8'h1);
    dp_done = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
